// File: rtl/arm7tdmi_multiply_iter_if.sv
// Start/busy/done handshake between the execute stage and the iterative multiplier.
// Defining ARM7_MUL_ABORT_EN adds the abort request line.
interface arm7tdmi_multiply_iter_if #(
  parameter int DATA_W     = 32,
  parameter int RADIX_BITS = 8
);
  localparam int NCHUNK = DATA_W / RADIX_BITS;
  localparam int CYC_W  = $clog2(NCHUNK + 3);

  logic              start;
  logic              mul_long;
  logic              mul_signed;
  logic              mul_accumulate;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] acc_hi;
  logic [DATA_W-1:0] acc_lo;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result_hi;
  logic [DATA_W-1:0] result_lo;
  logic              negative;
  logic              zero;
  logic [CYC_W-1:0]  cycles;
`ifdef ARM7_MUL_ABORT_EN
  logic              abort;

  modport master (
    output start, mul_long, mul_signed, mul_accumulate,
    output operand_a, operand_b, acc_hi, acc_lo, abort,
    input  busy, done, result_hi, result_lo, negative, zero, cycles
  );

  modport slave (
    input  start, mul_long, mul_signed, mul_accumulate,
    input  operand_a, operand_b, acc_hi, acc_lo, abort,
    output busy, done, result_hi, result_lo, negative, zero, cycles
  );
`else
  modport master (
    output start, mul_long, mul_signed, mul_accumulate,
    output operand_a, operand_b, acc_hi, acc_lo,
    input  busy, done, result_hi, result_lo, negative, zero, cycles
  );

  modport slave (
    input  start, mul_long, mul_signed, mul_accumulate,
    input  operand_a, operand_b, acc_hi, acc_lo,
    output busy, done, result_hi, result_lo, negative, zero, cycles
  );
`endif
endinterface

// File: rtl/arm7tdmi_multiply_iter.sv
// Iterative ARM7 multiplier (MUL/MLA/xMULL/xMLAL), RADIX_BITS of Rs per cycle with early termination.
// Optional abort input enabled by defining ARM7_MUL_ABORT_EN.
module arm7tdmi_multiply_iter #(
  parameter int DATA_W     = 32,
  parameter int RADIX_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  arm7tdmi_multiply_iter_if.slave bus
);
  localparam int NCHUNK = DATA_W / RADIX_BITS;
  localparam int CNT_W  = $clog2(NCHUNK + 1);
  localparam int CYC_W  = $clog2(NCHUNK + 3);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_EXTRA} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          iter_q, iter_d;
  logic [1:0]                ecnt_q, ecnt_d;
  logic [CNT_W-1:0]          m_q, m_d;
  logic [1:0]                extra_q, extra_d;
  logic                      long_q, long_d;
  logic                      sext_q, sext_d;
  logic signed [PROD_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0]         mplier_q, mplier_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic                      done_q, done_d;
  logic [DATA_W-1:0]         result_hi_q, result_hi_d;
  logic [DATA_W-1:0]         result_lo_q, result_lo_d;
  logic                      negative_q, negative_d;
  logic                      zero_q, zero_d;
  logic [CYC_W-1:0]          cycles_q, cycles_d;

  logic [CNT_W-1:0]          iter_nxt;
  logic                      last_iter;
  logic                      finish;
  logic                      signed_chk;
  logic                      signed_long;
  logic signed [PROD_W-1:0]  pp;
  logic signed [PROD_W-1:0]  sum;
  logic signed [PROD_W-1:0]  fin_val;

  // Smallest k whose multiplier bits above chunk k are pure sign/zero extension.
  function automatic logic [CNT_W-1:0] calc_iters(input logic [DATA_W-1:0] b,
                                                  input logic            chk_ones);
    logic [CNT_W-1:0] m;
    m = CNT_W'(NCHUNK);
    for (int k = NCHUNK - 1; k >= 1; k--) begin
      if (((b >> (k * RADIX_BITS)) == '0) ||
          (chk_ones && ((~b >> (k * RADIX_BITS)) == '0)))
        m = CNT_W'(k);
    end
    return m;
  endfunction

  // The final chunk of a sign-terminated multiplier carries weight -2^RADIX_BITS on its extension bit.
  function automatic logic signed [PROD_W-1:0] chunk_ext(input logic [RADIX_BITS-1:0] c,
                                                         input logic                  neg);
    return $signed({{(PROD_W - RADIX_BITS){neg}}, c});
  endfunction

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    ecnt_d      = ecnt_q;
    m_d         = m_q;
    extra_d     = extra_q;
    long_d      = long_q;
    sext_d      = sext_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    done_d      = 1'b0;
    result_hi_d = result_hi_q;
    result_lo_d = result_lo_q;
    negative_d  = negative_q;
    zero_d      = zero_q;
    cycles_d    = cycles_q;
    finish      = 1'b0;
    fin_val     = prod_q;

    signed_chk  = !bus.mul_long || bus.mul_signed;
    signed_long = bus.mul_long && bus.mul_signed;
    iter_nxt    = iter_q + CNT_W'(1);
    last_iter   = (iter_nxt == m_q);
    pp          = mcand_q * chunk_ext(mplier_q[RADIX_BITS-1:0], last_iter && sext_q);
    sum         = prod_q + pp;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_ITER;
          iter_d   = '0;
          ecnt_d   = '0;
          m_d      = calc_iters(bus.operand_b, signed_chk);
          extra_d  = {1'b0, bus.mul_long} + {1'b0, bus.mul_accumulate};
          long_d   = bus.mul_long;
          sext_d   = signed_chk && bus.operand_b[DATA_W-1];
          mcand_d  = $signed({{DATA_W{signed_long && bus.operand_a[DATA_W-1]}}, bus.operand_a});
          mplier_d = bus.operand_b;
          // Accumulator is preloaded so the extra cycles only model ARM7 timing.
          if (!bus.mul_accumulate)
            prod_d = '0;
          else if (bus.mul_long)
            prod_d = $signed({bus.acc_hi, bus.acc_lo});
          else
            prod_d = $signed({{DATA_W{1'b0}}, bus.acc_lo});
        end
      end
      S_ITER: begin
        prod_d   = sum;
        mcand_d  = mcand_q <<< RADIX_BITS;
        mplier_d = mplier_q >> RADIX_BITS;
        iter_d   = iter_nxt;
        if (last_iter) begin
          if (extra_q == 2'd0) begin
            finish  = 1'b1;
            fin_val = sum;
          end else begin
            state_d = S_EXTRA;
          end
        end
      end
      S_EXTRA: begin
        ecnt_d = ecnt_q + 2'd1;
        if (ecnt_d == extra_q)
          finish = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d  = S_IDLE;
      done_d   = 1'b1;
      cycles_d = CYC_W'(m_q) + CYC_W'(extra_q);
      if (long_q) begin
        result_hi_d = fin_val[PROD_W-1:DATA_W];
        result_lo_d = fin_val[DATA_W-1:0];
        negative_d  = fin_val[PROD_W-1];
        zero_d      = (fin_val == '0);
      end else begin
        result_hi_d = '0;
        result_lo_d = fin_val[DATA_W-1:0];
        negative_d  = fin_val[DATA_W-1];
        zero_d      = (fin_val[DATA_W-1:0] == '0);
      end
    end

`ifdef ARM7_MUL_ABORT_EN
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      done_d      = 1'b0;
      result_hi_d = result_hi_q;
      result_lo_d = result_lo_q;
      negative_d  = negative_q;
      zero_d      = zero_q;
      cycles_d    = cycles_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      iter_q      <= '0;
      ecnt_q      <= '0;
      done_q      <= 1'b0;
      result_hi_q <= '0;
      result_lo_q <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      ecnt_q      <= ecnt_d;
      done_q      <= done_d;
      result_hi_q <= result_hi_d;
      result_lo_q <= result_lo_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
      cycles_q    <= cycles_d;
    end
  end

  // Operand capture and partial-product datapath
  always_ff @(posedge clk) begin
    m_q      <= m_d;
    extra_q  <= extra_d;
    long_q   <= long_d;
    sext_q   <= sext_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.result_hi = result_hi_q;
  assign bus.result_lo = result_lo_q;
  assign bus.negative  = negative_q;
  assign bus.zero      = zero_q;
  assign bus.cycles    = cycles_q;
endmodule

// File: tb/tb_arm7tdmi_multiply_iter.sv
// Self-checking bench for arm7tdmi_multiply_iter against an arithmetic reference model.
module tb_arm7tdmi_multiply_iter;
  localparam int DW  = 32;
  localparam int RB  = 8;
  localparam int NCH = DW / RB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  arm7tdmi_multiply_iter_if #(.DATA_W(DW), .RADIX_BITS(RB)) mif();
  arm7tdmi_multiply_iter #(.DATA_W(DW), .RADIX_BITS(RB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lng;
    logic        sgn;
    logic        acc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ah;
    logic [31:0] al;
  } op_t;

  function automatic op_t mk_op(input logic lng, input logic sgn, input logic acc,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ah, input logic [31:0] al);
    op_t o;
    o.lng = lng; o.sgn = sgn; o.acc = acc;
    o.a = a; o.b = b; o.ah = ah; o.al = al;
    return o;
  endfunction

  // Reference: plain 64-bit arithmetic plus the termination rule read bit by bit.
  function automatic void model(input op_t op, output logic [63:0] r,
                                output logic [1:0] nz, output int lat);
    longint sa, sb;
    logic [63:0] p, accv;
    logic [31:0] lo;
    bit sc, allz, allo;
    int m;
    sc = !op.lng || op.sgn;
    m = NCH;
    for (int k = NCH - 1; k >= 1; k--) begin
      allz = 1'b1;
      allo = 1'b1;
      for (int j = k * RB; j < DW; j++) begin
        if (op.b[j]) allz = 1'b0;
        else allo = 1'b0;
      end
      if (allz || (sc && allo)) m = k;
    end
    lat = m + int'(op.lng) + int'(op.acc);
    if (op.lng) begin
      if (op.sgn) begin
        sa = longint'($signed(op.a));
        sb = longint'($signed(op.b));
      end else begin
        sa = longint'({32'd0, op.a});
        sb = longint'({32'd0, op.b});
      end
      accv = op.acc ? {op.ah, op.al} : 64'd0;
      p = 64'(sa * sb) + accv;
      r = p;
      nz = {p[63], p == 64'd0};
    end else begin
      lo = op.a * op.b + (op.acc ? op.al : 32'd0);
      r = {32'd0, lo};
      nz = {lo[31], lo == 32'd0};
    end
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.lng = ($urandom_range(0, 1) == 1);
    o.sgn = ($urandom_range(0, 1) == 1);
    o.acc = ($urandom_range(0, 1) == 1);
    o.a   = $urandom();
    o.b   = $urandom() >> (8 * $urandom_range(0, 4));
    if ($urandom_range(0, 2) == 0) o.b = ~o.b;
    o.ah  = $urandom();
    o.al  = $urandom();
    return o;
  endfunction

  task automatic drive_op(input op_t op);
    mif.mul_long       = op.lng;
    mif.mul_signed     = op.sgn;
    mif.mul_accumulate = op.acc;
    mif.operand_a      = op.a;
    mif.operand_b      = op.b;
    mif.acc_hi         = op.ah;
    mif.acc_lo         = op.al;
    mif.start          = 1'b1;
  endtask

  // Issues one op and waits (bounded) for done; lat counts cycles after the start edge.
  task automatic run_op(input op_t op, output int lat, output bit got, output bit busy_ok);
    drive_op(op);
    @(posedge clk); #1;
    mif.start = 1'b0;
    busy_ok = mif.busy;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(posedge clk); #1;
      if (mif.done) begin
        got = 1'b1;
        lat = c;
        if (mif.busy) busy_ok = 1'b0;
      end else if (!mif.busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if ({mif.busy, mif.done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b required 00", {mif.busy, mif.done}); end
    checks++; if ({mif.result_hi, mif.result_lo} !== 64'd0) begin errors++; $display("FAIL reset_result: got %h required 0", {mif.result_hi, mif.result_lo}); end
    checks++; if ({mif.negative, mif.zero} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b required 00", {mif.negative, mif.zero}); end
    checks++; if (mif.cycles !== 3'd0) begin errors++; $display("FAIL reset_cycles: got %0d required 0", mif.cycles); end
    @(posedge clk); #1;
    checks++; if ({mif.busy, mif.done} !== 2'b00) begin errors++; $display("FAIL post_reset_idle: got %b required 00", {mif.busy, mif.done}); end
  endtask

  task automatic test_directed();
    op_t         ops   [4];
    logic [63:0] exp_r [4];
    logic [1:0]  exp_nz[4];
    int          exp_l [4];
    int lat; bit got, bok;
    ops[0] = mk_op(1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0);
    exp_r[0] = 64'd35; exp_nz[0] = 2'b00; exp_l[0] = 1;
    ops[1] = mk_op(1'b0, 1'b0, 1'b1, 32'd3, 32'd4, 32'd0, 32'd2);
    exp_r[1] = 64'd14; exp_nz[1] = 2'b00; exp_l[1] = 2;
    ops[2] = mk_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    exp_r[2] = 64'hFFFF_FFFE_0000_0001; exp_nz[2] = 2'b10; exp_l[2] = 5;
    ops[3] = mk_op(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    exp_r[3] = 64'h0000_0000_0000_0001; exp_nz[3] = 2'b00; exp_l[3] = 2;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], lat, got, bok);
      checks++; if (!got || lat != exp_l[i]) begin errors++; $display("FAIL dir_latency[%0d]: got %0d (done seen %0b) required %0d", i, lat, got, exp_l[i]); end
      checks++; if ({mif.result_hi, mif.result_lo} !== exp_r[i]) begin errors++; $display("FAIL dir_result[%0d]: got %h required %h", i, {mif.result_hi, mif.result_lo}, exp_r[i]); end
      checks++; if ({mif.negative, mif.zero} !== exp_nz[i]) begin errors++; $display("FAIL dir_flags[%0d]: got %b required %b", i, {mif.negative, mif.zero}, exp_nz[i]); end
      checks++; if (mif.cycles !== 3'(exp_l[i])) begin errors++; $display("FAIL dir_cycles[%0d]: got %0d required %0d", i, mif.cycles, exp_l[i]); end
      checks++; if (!bok) begin errors++; $display("FAIL dir_busy[%0d]: got busy pattern wrong required busy high until done", i); end
      @(posedge clk); #1;
      checks++; if (mif.done !== 1'b0 || {mif.result_hi, mif.result_lo} !== exp_r[i]) begin errors++; $display("FAIL dir_hold[%0d]: got done=%b res=%h required done=0 res=%h", i, mif.done, {mif.result_hi, mif.result_lo}, exp_r[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit got, bok;
    run_op(mk_op(1'b1, 1'b0, 1'b1, 32'd2, 32'h0001_2345, 32'h0000_0001, 32'hFFFF_FFFF), lat, got, bok);
    checks++; if (!got || lat != 5) begin errors++; $display("FAIL umlal_latency: got %0d required 5", lat); end
    checks++; if ({mif.result_hi, mif.result_lo} !== 64'h0000_0002_0002_4689) begin errors++; $display("FAIL umlal_result: got %h required 0000000200024689", {mif.result_hi, mif.result_lo}); end
    checks++; if (mif.cycles !== 3'd5) begin errors++; $display("FAIL umlal_cycles: got %0d required 5", mif.cycles); end
    run_op(mk_op(1'b0, 1'b0, 1'b0, 32'd0, 32'd42, 32'd0, 32'd0), lat, got, bok);
    checks++; if (!got || lat != 1) begin errors++; $display("FAIL b2b_latency: got %0d required 1", lat); end
    checks++; if ({mif.result_hi, mif.result_lo} !== 64'd0) begin errors++; $display("FAIL b2b_result: got %h required 0", {mif.result_hi, mif.result_lo}); end
    checks++; if ({mif.negative, mif.zero} !== 2'b01) begin errors++; $display("FAIL b2b_flags: got %b required 01", {mif.negative, mif.zero}); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    op_t op; logic [63:0] er; logic [1:0] enz; int el, lat; bit got;
    op = mk_op(1'b1, 1'b0, 1'b0, 32'h8765_4321, 32'hFFFF_FFFF, 32'd0, 32'd0);
    model(op, er, enz, el);
    drive_op(op);
    @(posedge clk); #1;
    mif.start = 1'b0;
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(posedge clk); #1;
      if (mif.done) begin got = 1'b1; lat = c; end
      if (c == 1) drive_op(mk_op(1'b0, 1'b0, 1'b1, 32'd3, 32'd3, 32'd0, 32'd9));
      if (c == 2) mif.start = 1'b0;
    end
    checks++; if (!got || lat != el) begin errors++; $display("FAIL busy_start_latency: got %0d required %0d", lat, el); end
    checks++; if ({mif.result_hi, mif.result_lo} !== er) begin errors++; $display("FAIL busy_start_result: got %h required %h", {mif.result_hi, mif.result_lo}, er); end
    @(posedge clk); #1;
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued: got busy=%b required 0", mif.busy); end
  endtask

  task automatic test_random();
    op_t op; logic [63:0] er; logic [1:0] enz; int el, lat; bit got, bok;
    for (int i = 0; i < 60; i++) begin
      op = rand_op();
      model(op, er, enz, el);
      run_op(op, lat, got, bok);
      checks++; if (!got || lat != el) begin errors++; $display("FAIL rand_latency[%0d]: got %0d (done seen %0b) required %0d", i, lat, got, el); end
      checks++; if ({mif.result_hi, mif.result_lo} !== er) begin errors++; $display("FAIL rand_result[%0d]: got %h required %h (op %h)", i, {mif.result_hi, mif.result_lo}, er, op); end
      checks++; if ({mif.negative, mif.zero} !== enz) begin errors++; $display("FAIL rand_flags[%0d]: got %b required %b", i, {mif.negative, mif.zero}, enz); end
      checks++; if (mif.cycles !== 3'(el)) begin errors++; $display("FAIL rand_cycles[%0d]: got %0d required %0d", i, mif.cycles, el); end
      checks++; if (!bok) begin errors++; $display("FAIL rand_busy[%0d]: got busy pattern wrong required busy high until done", i); end
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int lat; bit got, bok, seen;
    run_op(mk_op(1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0), lat, got, bok);
    checks++; if (!got || mif.result_lo !== 32'd81) begin errors++; $display("FAIL pre_reset_op: got %h required %h", mif.result_lo, 32'd81); end
    @(posedge clk); #1;
    drive_op(mk_op(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 32'd0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if ({mif.busy, mif.done, mif.negative, mif.zero} !== 4'b0000) begin errors++; $display("FAIL midrst_ctrl: got %b required 0000", {mif.busy, mif.done, mif.negative, mif.zero}); end
    checks++; if ({mif.result_hi, mif.result_lo} !== 64'd0) begin errors++; $display("FAIL midrst_result: got %h required 0", {mif.result_hi, mif.result_lo}); end
    checks++; if (mif.cycles !== 3'd0) begin errors++; $display("FAIL midrst_cycles: got %0d required 0", mif.cycles); end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (mif.done || mif.busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_done: got activity=1 required 0"); end
  endtask

`ifdef ARM7_MUL_ABORT_EN
  task automatic test_abort();
    op_t op; logic [63:0] er; logic [1:0] enz; int el, lat; bit got, bok, seen;
    op = mk_op(1'b0, 1'b0, 1'b1, 32'd6, 32'd7, 32'd0, 32'd100);
    model(op, er, enz, el);
    run_op(op, lat, got, bok);
    checks++; if (!got || {mif.result_hi, mif.result_lo} !== er) begin errors++; $display("FAIL pre_abort_op: got %h required %h", {mif.result_hi, mif.result_lo}, er); end
    @(posedge clk); #1;
    drive_op(mk_op(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd0, 32'd0));
    @(posedge clk); #1;
    mif.start = 1'b0;
    @(posedge clk); #1;
    mif.abort = 1'b1;
    @(posedge clk); #1;
    mif.abort = 1'b0;
    checks++; if ({mif.busy, mif.done} !== 2'b00) begin errors++; $display("FAIL abort_ctrl: got %b required 00", {mif.busy, mif.done}); end
    checks++; if ({mif.result_hi, mif.result_lo} !== er || mif.cycles !== 3'(el)) begin errors++; $display("FAIL abort_retain: got %h/%0d required %h/%0d", {mif.result_hi, mif.result_lo}, mif.cycles, er, el); end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (mif.done) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_done: got done=1 required 0"); end
    mif.abort = 1'b1;
    drive_op(mk_op(1'b0, 1'b0, 1'b0, 32'd11, 32'd13, 32'd0, 32'd0));
    @(posedge clk); #1;
    mif.start = 1'b0;
    mif.abort = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(posedge clk); #1;
      if (mif.done) got = 1'b1;
    end
    checks++; if (!got || mif.result_lo !== 32'd143) begin errors++; $display("FAIL abort_start_wins: got done=%b res=%h required 1/%h", got, mif.result_lo, 32'd143); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    mif.start          = 1'b0;
    mif.mul_long       = 1'b0;
    mif.mul_signed     = 1'b0;
    mif.mul_accumulate = 1'b0;
    mif.operand_a      = '0;
    mif.operand_b      = '0;
    mif.acc_hi         = '0;
    mif.acc_lo         = '0;
`ifdef ARM7_MUL_ABORT_EN
    mif.abort          = 1'b0;
`endif
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_while_busy();
    test_random();
`ifdef ARM7_MUL_ABORT_EN
    test_abort();
`endif
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
